// File: rtl/bram_fifo_ctrl_if.sv
// bram_fifo_ctrl_if: producer/consumer valid-ready handshake of the BRAM FIFO controller
interface bram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
  modport slave  (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: sequences a registered-read 1R1W block RAM into a valid/ready FIFO with a 2-entry output queue
module bram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_COL    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_fifo_ctrl_if.slave       fifo,
  output logic [ADDR_WIDTH+1:0] count_o,
  output logic [NUM_COL-1:0]    ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);
  typedef enum logic {PRIO_WR, PRIO_RD} prio_e;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  logic                  act_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q;
  prio_e                 prio_q, prio_d;
  logic [1:0]            oq_cnt_q, oq_cnt_d;
  logic [DATA_WIDTH-1:0] oq0_q, oq0_d, oq1_q, oq1_d;
  logic                  not_full, not_empty, pop, want_rd, want_wr, wr_ready, push, rd_go, slot0;
  logic [2:0]            oq_next;
  always_comb begin
    not_full  = ram_cnt_q != FULL;
    not_empty = ram_cnt_q != '0;
    pop       = (oq_cnt_q != 2'd0) & fifo.rd_ready;
    oq_next   = {1'b0, oq_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    want_rd   = not_empty & (oq_next < 3'd2);
    // wr_ready depends only on state and rd_ready, never on wr_valid
    wr_ready  = act_q & not_full & ~(want_rd & (prio_q == PRIO_RD));
    want_wr   = fifo.wr_valid & act_q & not_full;
    push      = fifo.wr_valid & wr_ready;
    rd_go     = want_rd & ~push;
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(rd_go);
    ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(rd_go);
    prio_d    = (want_wr & want_rd) ? ((prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR) : prio_q;
    oq_cnt_d  = oq_next[1:0];
    // a returning word lands in the first slot left free after this cycle's pop
    slot0     = inflight_q & (oq_cnt_q == {1'b0, pop});
    oq0_d     = slot0 ? ram_rd_data_i : (pop ? oq1_q : oq0_q);
    oq1_d     = (inflight_q & ~slot0) ? ram_rd_data_i : oq1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      prio_q     <= PRIO_WR;
      oq_cnt_q   <= '0;
      oq0_q      <= '0;
      oq1_q      <= '0;
    end else begin
      act_q      <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= rd_go;
      prio_q     <= prio_d;
      oq_cnt_q   <= oq_cnt_d;
      oq0_q      <= oq0_d;
      oq1_q      <= oq1_d;
    end
  end
  assign fifo.wr_ready = wr_ready;
  assign fifo.rd_valid = oq_cnt_q != 2'd0;
  assign fifo.rd_data  = oq0_q;
  assign count_o       = (ADDR_WIDTH+2)'(ram_cnt_q) + (ADDR_WIDTH+2)'(inflight_q) + (ADDR_WIDTH+2)'(oq_cnt_q);
  assign ram_wr_en_o   = {NUM_COL{push}};
  assign ram_wr_addr_o = wr_ptr_q;
  assign ram_wr_data_o = fifo.wr_data;
  assign ram_rd_addr_o = rd_ptr_q;
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: random and directed stimulus against a queue-based FIFO reference model
module tb_bram_fifo_ctrl;
  localparam int AW = 4, DW = 8, NC = 1, DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bram_fifo_ctrl_if #(.DATA_WIDTH(DW)) fifo ();
  logic [AW+1:0] count;
  logic [NC-1:0] ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk)
    if (|ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    else ram_rd_data <= mem[ram_rd_addr];
  bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COL(NC)) dut (
    .clk(clk), .rst_n(rst_n), .fifo(fifo), .count_o(count),
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
    .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data));
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] model_q[$];
  int wr_total = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data;
  // Reference model: accepted words queue up in order; occupancy is accepted minus popped
  always @(negedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      wr_total = 0;
      prev_stall = 0;
    end else begin
      automatic bit push = fifo.wr_valid & fifo.wr_ready;
      automatic bit pop = fifo.rd_valid & fifo.rd_ready;
      automatic logic [DW-1:0] head = (model_q.size() > 0) ? model_q[0] : 'x;
      n_chk++;
      if (int'(count) !== model_q.size()) $display("FAIL mon_count: got %0d want %0d", count, model_q.size());
      else n_pass++;
      n_chk++;
      if (ram_wr_en !== {NC{push}}) $display("FAIL mon_wr_en: got %b want %b", ram_wr_en, {NC{push}});
      else n_pass++;
      if (push) begin
        n_chk++;
        if (ram_wr_addr !== AW'(wr_total) || ram_wr_data !== fifo.wr_data)
          $display("FAIL mon_wr_port: addr %0d data %h want addr %0d data %h", ram_wr_addr, ram_wr_data, AW'(wr_total), fifo.wr_data);
        else n_pass++;
      end
      if (model_q.size() == DEPTH + 2) begin
        n_chk++;
        if (fifo.wr_ready !== 1'b0) $display("FAIL mon_full_ready: got %b want 0", fifo.wr_ready);
        else n_pass++;
      end
      if (fifo.rd_valid) begin
        n_chk++;
        if (model_q.size() == 0 || fifo.rd_data !== head) $display("FAIL mon_head: got %h want %h (model size %0d)", fifo.rd_data, head, model_q.size());
        else n_pass++;
      end
      if (prev_stall) begin
        n_chk++;
        if (fifo.rd_valid !== 1'b1 || fifo.rd_data !== prev_data) $display("FAIL mon_stall: valid %b data %h want 1 %h", fifo.rd_valid, fifo.rd_data, prev_data);
        else n_pass++;
      end
      prev_stall = fifo.rd_valid & ~fifo.rd_ready;
      prev_data = fifo.rd_data;
      if (pop && model_q.size() > 0) void'(model_q.pop_front());
      if (push) begin
        model_q.push_back(fifo.wr_data);
        wr_total++;
      end
    end
  end
  task automatic drain();
    for (int c = 0; c < 80 && count != 0; c++) begin
      @(posedge clk); #1;
      fifo.wr_valid = 1'b0;
      fifo.rd_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    fifo.rd_ready = 1'b0;
  endtask
  task automatic test_reset();
    fifo.wr_valid = 1'b1;
    fifo.rd_ready = 1'b0;
    fifo.wr_data = '0;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (fifo.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", fifo.rd_valid); else n_pass++;
    n_chk++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (fifo.wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", fifo.wr_ready); else n_pass++;
    n_chk++; if (ram_wr_en !== '0) $display("FAIL reset_wr_en: got %b want 0", ram_wr_en); else n_pass++;
    fifo.wr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (fifo.wr_ready !== 1'b1) $display("FAIL release_wr_ready: got %b want 1", fifo.wr_ready); else n_pass++;
  endtask
  task automatic test_latency();
    @(posedge clk); #1;
    fifo.rd_ready = 1'b0;
    fifo.wr_valid = 1'b1;
    fifo.wr_data = 8'h5A;
    @(negedge clk);
    n_chk++; if (fifo.wr_ready !== 1'b1) $display("FAIL latency_push: wr_ready %b want 1", fifo.wr_ready); else n_pass++;
    @(posedge clk); #1;
    fifo.wr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_chk++;
      if (fifo.rd_valid !== (k == 3)) $display("FAIL latency_T%0d: rd_valid %b want %b", k, fifo.rd_valid, k == 3);
      else n_pass++;
      if (k < 3) begin @(posedge clk); #1; end
    end
    n_chk++; if (fifo.rd_data !== 8'h5A) $display("FAIL latency_data: got %h want 5a", fifo.rd_data); else n_pass++;
    drain();
  endtask
  task automatic test_order();
    logic [DW-1:0] got[$];
    int idx = 0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(posedge clk); #1;
      fifo.rd_ready = 1'b1;
      fifo.wr_valid = idx < 4;
      fifo.wr_data = 8'(8'h11 + idx);
      @(negedge clk);
      if (fifo.wr_valid && fifo.wr_ready) idx++;
      if (fifo.rd_valid && fifo.rd_ready) got.push_back(fifo.rd_data);
    end
    @(posedge clk); #1;
    fifo.wr_valid = 1'b0;
    fifo.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== 8'(8'h11 + i)) $display("FAIL order_pop%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(8'h11 + i));
      else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (count !== '0) $display("FAIL order_count: got %0d want 0", count); else n_pass++;
  endtask
  task automatic test_full();
    int idx = 0, full_wr = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      fifo.rd_ready = 1'b0;
      fifo.wr_valid = idx < 20;
      fifo.wr_data = 8'(8'h80 + idx);
      @(negedge clk);
      if (count == DEPTH + 2 && |ram_wr_en) full_wr++;
      if (fifo.wr_valid && fifo.wr_ready) idx++;
    end
    n_chk++; if (idx != DEPTH + 2) $display("FAIL full_accepted: got %0d want %0d", idx, DEPTH + 2); else n_pass++;
    n_chk++; if (count !== 6'(DEPTH + 2)) $display("FAIL full_count: got %0d want %0d", count, DEPTH + 2); else n_pass++;
    n_chk++; if (fifo.wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %b want 0", fifo.wr_ready); else n_pass++;
    n_chk++; if (full_wr != 0) $display("FAIL full_write: got %0d writes while full want 0", full_wr); else n_pass++;
    drain();
    @(negedge clk);
    n_chk++; if (count !== '0) $display("FAIL full_drain: got %0d want 0", count); else n_pass++;
  endtask
  task automatic test_alternate();
    int idx = 0, viol = 0, writes = 0, pops = 0;
    bit we_prev = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      fifo.rd_ready = 1'b0;
      fifo.wr_valid = idx < 8;
      fifo.wr_data = 8'(8'hC0 + idx);
      @(negedge clk);
      if (fifo.wr_valid && fifo.wr_ready) idx++;
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      fifo.rd_ready = 1'b1;
      fifo.wr_valid = 1'b1;
      fifo.wr_data = 8'(8'hD0 + c);
      @(negedge clk);
      if (c > 0 && (|ram_wr_en) == we_prev) viol++;
      we_prev = |ram_wr_en;
      if (|ram_wr_en) writes++;
      if (fifo.rd_valid) pops++;
    end
    n_chk++; if (viol != 0) $display("FAIL alt_pattern: got %0d non-alternating cycles want 0", viol); else n_pass++;
    n_chk++; if (writes != 10) $display("FAIL alt_writes: got %0d want 10", writes); else n_pass++;
    n_chk++; if (pops < 8) $display("FAIL alt_pops: got %0d want >= 8", pops); else n_pass++;
    drain();
  endtask
  task automatic test_random();
    logic [DW-1:0] sent[$], got[$];
    bit hold = 0;
    int bad = 0;
    for (int c = 0; c < 3000 && got.size() < 3 * DEPTH; c++) begin
      @(posedge clk); #1;
      if (!hold) begin
        fifo.wr_valid = (sent.size() < 3 * DEPTH) && ($urandom_range(0, 99) < 60);
        fifo.wr_data = 8'($urandom);
      end
      fifo.rd_ready = $urandom_range(0, 99) < 50;
      @(negedge clk);
      if (fifo.rd_valid && fifo.rd_ready) got.push_back(fifo.rd_data);
      if (fifo.wr_valid && fifo.wr_ready) begin
        sent.push_back(fifo.wr_data);
        hold = 0;
      end else hold = fifo.wr_valid;
    end
    @(posedge clk); #1;
    fifo.wr_valid = 1'b0;
    fifo.rd_ready = 1'b0;
    n_chk++; if (got.size() != 3 * DEPTH) $display("FAIL rand_popped: got %0d want %0d", got.size(), 3 * DEPTH); else n_pass++;
    for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) bad++;
    n_chk++; if (bad != 0) $display("FAIL rand_order: got %0d wrong words want 0", bad); else n_pass++;
    @(negedge clk);
    n_chk++; if (count !== '0) $display("FAIL rand_count: got %0d want 0", count); else n_pass++;
  endtask
  task automatic test_reset_mid();
    int spurious = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      fifo.rd_ready = 1'b0;
      fifo.wr_valid = c < 6;
      fifo.wr_data = 8'(8'hE0 + c);
      @(negedge clk);
    end
    @(posedge clk); #1;
    fifo.wr_valid = 1'b0;
    fifo.rd_ready = 1'b1;
    @(posedge clk); #1;
    fifo.rd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++; if (fifo.rd_valid !== 1'b0) $display("FAIL midrst_rd_valid: got %b want 0", fifo.rd_valid); else n_pass++;
    n_chk++; if (count !== '0) $display("FAIL midrst_count: got %0d want 0", count); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fifo.rd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo.rd_valid || count != 0) spurious++;
    end
    n_chk++; if (spurious != 0) $display("FAIL midrst_spurious: got %0d cycles with output want 0", spurious); else n_pass++;
    fifo.rd_ready = 1'b0;
  endtask
  initial begin
    fifo.wr_valid = 1'b0;
    fifo.rd_ready = 1'b0;
    fifo.wr_data = '0;
    test_reset();
    test_latency();
    test_order();
    test_full();
    test_alternate();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
